fifo_wr_arb_cntrl: RTL and testbench

- Single-clock controller for the 8-entry FIFO memory.
- Shares the memory write port between two requesters, using round-robin arbitration with valid/ready handshakes.
- Owns the read/write pointers and generates wclken/waddr/wdata/raddr for the memory.
- Exposes empty/full/almost_full/count status to the consumer, which pops with rd_en and samples memory rdata combinationally.

---
 rtl/fifo_wr_arb_cntrl.sv | 101 ++++++++++
 tb/tb_fifo_wr_arb_cntrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb_cntrl.sv
// Write-port arbiter and pointer/status controller for an external 2**ADDR_WIDTH-entry FIFO memory.
// Two requesters share the write port in round-robin order. The consumer pops the head with rd_en.
module fifo_wr_arb_cntrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  rd_en,
    output logic                  wclken,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  last_grant
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                last_grant_q, last_grant_d;

    logic grant_vld;
    logic grant_id;
    logic accept;
    logic pop;

    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign almost_full = (count_q >= AF_CNT);
    assign count       = count_q;
    assign last_grant  = last_grant_q;
    assign waddr       = wr_ptr_q[ADDR_WIDTH-1:0];
    assign raddr       = rd_ptr_q[ADDR_WIDTH-1:0];

    // Handshakes are suppressed while reset is asserted so no word is lost to a reset edge.
    assign accept     = RST_n && grant_vld && !full;
    assign pop        = rd_en && !empty;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;
    assign wclken     = accept;
    assign wdata      = grant_id ? req1_data : req0_data;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            wr_ptr_d     = wr_ptr_q + ONE;
            last_grant_d = grant_id;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        if (accept && !pop) begin
            count_d = count_q + ONE;
        end else if (pop && !accept) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb_cntrl.sv
// Scoreboard bench for fifo_wr_arb_cntrl: directed scenarios followed by random traffic, checked against a queue-based FIFO model.
module tb_fifo_wr_arb_cntrl;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       req0_valid, req1_valid, rd_en;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, wclken;
    logic [2:0] waddr, raddr;
    logic [7:0] wdata;
    logic       empty, full, almost_full, last_grant;
    logic [3:0] count;

    logic [7:0] mem [8];
    logic [7:0] rdata;

    always #5 CLK = ~CLK;

    fifo_wr_arb_cntrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rd_en(rd_en), .wclken(wclken), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .empty(empty), .full(full), .almost_full(almost_full), .count(count),
        .last_grant(last_grant)
    );

    // External memory: registered write, combinational read.
    always @(posedge CLK) if (wclken) mem[waddr] <= wdata;
    assign rdata = mem[raddr];

    typedef struct {
        logic       wclken, r0, r1, empty, full, af, lg, has_head;
        logic [2:0] waddr, raddr;
        logic [7:0] wdata, head;
        logic [3:0] count;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0] fifo_m[$];
    int unsigned wcnt, rcnt;
    logic        lastg;
    int unsigned acc0, acc1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        wcnt  = 0;
        rcnt  = 0;
        lastg = 1'b1;
    endtask

    // One cycle: drive inputs, predict outputs, then advance the model across the next edge.
    task automatic step(input logic rst_n, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1, input logic rd);
        exp_t e;
        logic g, acc, pp;
        @(posedge CLK);
        #1;
        RST_n = rst_n; req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1; rd_en = rd;

        g   = (v0 && v1) ? !lastg : (v1 ? 1'b1 : 1'b0);
        acc = rst_n && (v0 || v1) && (fifo_m.size() < 8);
        pp  = rd && (fifo_m.size() > 0);

        e.wclken   = acc;
        e.r0       = acc && !g;
        e.r1       = acc && g;
        e.wdata    = g ? d1 : d0;
        e.waddr    = 3'(wcnt % 8);
        e.raddr    = 3'(rcnt % 8);
        e.empty    = (fifo_m.size() == 0);
        e.full     = (fifo_m.size() == 8);
        e.af       = (fifo_m.size() >= 6);
        e.count    = 4'(fifo_m.size());
        e.lg       = lastg;
        e.has_head = (fifo_m.size() > 0);
        e.head     = (fifo_m.size() > 0) ? fifo_m[0] : 8'h00;
        exp_q.push_back(e);

        if (!rst_n) begin
            model_reset();
        end else begin
            if (pp) begin
                void'(fifo_m.pop_front());
                rcnt = (rcnt + 1) % 16;
            end
            if (acc) begin
                fifo_m.push_back(g ? d1 : d0);
                wcnt  = (wcnt + 1) % 16;
                lastg = g;
                if (g) acc1++; else acc0++;
            end
        end
    endtask

    // Monitor: compares each cycle's DUT outputs against the predicted entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wclken",      32'(wclken),      32'(e.wclken));
                chk("req0_ready",  32'(req0_ready),  32'(e.r0));
                chk("req1_ready",  32'(req1_ready),  32'(e.r1));
                chk("empty",       32'(empty),       32'(e.empty));
                chk("full",        32'(full),        32'(e.full));
                chk("almost_full", 32'(almost_full), 32'(e.af));
                chk("count",       32'(count),       32'(e.count));
                chk("last_grant",  32'(last_grant),  32'(e.lg));
                chk("waddr",       32'(waddr),       32'(e.waddr));
                chk("raddr",       32'(raddr),       32'(e.raddr));
                if (e.wclken)   chk("wdata", 32'(wdata), 32'(e.wdata));
                if (e.has_head) chk("rdata", 32'(rdata), 32'(e.head));
            end
        end
    end

    initial begin
        RST_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rd_en = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        acc0 = 0; acc1 = 0;
        @(posedge CLK);
        model_reset();

        // Reset held with both requesters valid, then a single req0 write
        step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        step(1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Round-robin fill from empty, then two more cycles while full
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        acc0 = 0; acc1 = 0;
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 8'(8'h10 + acc0), 1'b1, 8'(8'h20 + acc1), 1'b0);

        // Full with simultaneous pop, then the deferred write wraps to address 0
        step(1'b1, 1'b1, 8'(8'h10 + acc0), 1'b1, 8'(8'h20 + acc1), 1'b1);
        step(1'b1, 1'b1, 8'(8'h10 + acc0), 1'b1, 8'(8'h20 + acc1), 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Empty with simultaneous pop and write
        step(1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Steady streaming: one write and one pop per cycle across pointer wrap
        for (int i = 0; i < 21; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Mid-operation reset at count 5, then contention goes to req0
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
        step(1'b1, 1'b1, 8'h99, 1'b1, 8'hAA, 1'b0);
        step(1'b1, 1'b1, 8'h9B, 1'b1, 8'hAB, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 2) != 0), 8'($urandom),
                 ($urandom_range(0, 2) != 0), 8'($urandom),
                 ($urandom_range(0, 1) != 0));
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
